// File: rtl/lpif_rx_packer.sv
// lpif_rx_packer: RX byte packer between the physical-layer packet decoder and the LPIF RX side.
// It drops invalid byte lanes, keeps byte order and keeps each byte's framing markers with it.
// When PACK=1, bytes left over from one cycle are carried into the next so output beats are full.
// A partial beat goes out early on an end marker (tlpend/dllpend/edb), on timeout, or on a GEN
// change. pl_state_sts and pl_speedmode are registered copies of state and GEN.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   packetValid / packetData        per-byte valid and data (byte i = packetData[8i+7:8i])
//   tlpstart/tlpend/dllpstart/dllpend/edb   per-byte markers, used only where the byte is valid
//   GEN, state                      link generation (1..5) and LTSSM/LPIF state code
//   pl_valid / pl_data              packed output beat; pl_valid is contiguous from bit 0
//   pl_tlpstart..pl_tlpedb          markers aligned to the pl_data bytes
//   pl_speedmode                    GEN-1 for GEN 1..5, otherwise 3'b111
//   pl_state_sts                    registered state
//   pl_drop                         one-cycle pulse when held bytes are discarded on leaving active
module lpif_rx_packer #(
  parameter int unsigned NBYTES       = 64,
  parameter int unsigned PACK         = 1,
  parameter int unsigned TIMEOUT      = 8,
  parameter logic [3:0]  ACTIVE_STATE = 4'h1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NBYTES-1:0]     packetValid,
  input  logic [8*NBYTES-1:0]   packetData,
  input  logic [NBYTES-1:0]     tlpstart,
  input  logic [NBYTES-1:0]     tlpend,
  input  logic [NBYTES-1:0]     dllpstart,
  input  logic [NBYTES-1:0]     dllpend,
  input  logic [NBYTES-1:0]     edb,
  input  logic [2:0]            GEN,
  input  logic [3:0]            state,
  output logic [NBYTES-1:0]     pl_valid,
  output logic [8*NBYTES-1:0]   pl_data,
  output logic [NBYTES-1:0]     pl_tlpstart,
  output logic [NBYTES-1:0]     pl_tlpend,
  output logic [NBYTES-1:0]     pl_dllpstart,
  output logic [NBYTES-1:0]     pl_dllpend,
  output logic [NBYTES-1:0]     pl_tlpedb,
  output logic [2:0]            pl_speedmode,
  output logic [3:0]            pl_state_sts,
  output logic                  pl_drop
);

  // Fill can briefly equal NBYTES after a GEN-change flush, so it needs the extra bit.
  localparam int unsigned FW  = $clog2(NBYTES) + 1;
  localparam int unsigned CW  = $clog2(2 * NBYTES);
  localparam int unsigned TW  = CW + 1;
  localparam int unsigned TMW = $clog2(TIMEOUT + 2);

  typedef struct packed {
    logic [7:0] data;
    logic       tlp_s;
    logic       tlp_e;
    logic       dllp_s;
    logic       dllp_e;
    logic       edb_m;
  } lane_t;

  typedef enum logic [0:0] {StEmpty, StPartial} state_e;

  lane_t [NBYTES-1:0]   acc_q, acc_d;
  logic  [FW-1:0]       fill_q, fill_d;
  logic  [TMW-1:0]      timer_q, timer_d;
  state_e               st_q, st_d;
  logic  [2:0]          gen_q;

  lane_t [NBYTES-1:0]   out_q, out_d;
  logic  [NBYTES-1:0]   valid_q, valid_d;
  logic                 drop_q, drop_d;
  logic  [2:0]          speed_q, speed_d;
  logic  [3:0]          sts_q;

  // Accumulator contents followed by this cycle's valid bytes, in byte order.
  lane_t [2*NBYTES-1:0] cat;
  logic  [CW-1:0]       base;
  logic  [CW-1:0]       pos;
  logic  [FW-1:0]       n;
  logic  [TW-1:0]       total;
  logic  [TW-1:0]       cnt;
  logic                 active;
  logic                 gen_flush;
  logic                 end_any;
  logic                 timeout;
  logic                 emit;

  always_comb begin
    active    = (state == ACTIVE_STATE);
    // A GEN change drains the held bytes on their own; new bytes start a fresh accumulator.
    gen_flush = (PACK != 0) && active && (st_q == StPartial) && (GEN != gen_q);
    base      = gen_flush ? '0 : CW'(fill_q);

    cat = '0;
    if (!gen_flush) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (FW'(i) < fill_q) cat[i] = acc_q[i];
      end
    end

    pos = base;
    n   = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (active && packetValid[i]) begin
        cat[pos] = '{data:   packetData[8*i +: 8],
                     tlp_s:  tlpstart[i],
                     tlp_e:  tlpend[i],
                     dllp_s: dllpstart[i],
                     dllp_e: dllpend[i],
                     edb_m:  edb[i]};
        pos = pos + 1'b1;
        n   = n + 1'b1;
      end
    end
    total = TW'(base) + TW'(n);

    // Lanes past total are zero, so OR-ing every lane only sees live markers.
    end_any = 1'b0;
    for (int j = 0; j < 2 * NBYTES; j++) begin
      end_any = end_any | cat[j].tlp_e | cat[j].dllp_e | cat[j].edb_m;
    end

    timeout = (TIMEOUT != 0) && (fill_q != '0) && (timer_q >= TMW'(TIMEOUT));
    emit    = 1'b0;
    cnt     = '0;
    out_d   = '0;
    acc_d   = '0;
    fill_d  = '0;
    timer_d = '0;
    drop_d  = 1'b0;

    if (!active) begin
      drop_d = (fill_q != '0);
    end else if (gen_flush) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (FW'(i) < fill_q) out_d[i] = acc_q[i];
      end
      cnt    = TW'(fill_q);
      acc_d  = cat[NBYTES-1:0];
      fill_d = n;
    end else if (PACK == 0) begin
      if (n != '0) begin
        out_d = cat[NBYTES-1:0];
        cnt   = TW'(n);
      end
    end else begin
      emit = (total >= TW'(NBYTES)) || end_any || timeout;
      if (emit) begin
        out_d = cat[NBYTES-1:0];
        if (total >= TW'(NBYTES)) begin
          cnt    = TW'(NBYTES);
          acc_d  = cat[2*NBYTES-1:NBYTES];
          fill_d = FW'(total - TW'(NBYTES));
        end else begin
          cnt = total;
        end
      end else begin
        acc_d  = cat[NBYTES-1:0];
        fill_d = FW'(total);
        if (st_q == StPartial && timer_q != '1) timer_d = timer_q + 1'b1;
      end
    end

    for (int i = 0; i < NBYTES; i++) begin
      valid_d[i] = (TW'(i) < cnt);
    end

    st_d = (fill_d != '0) ? StPartial : StEmpty;

    case (GEN)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: speed_d = GEN - 3'd1;
      default:                       speed_d = 3'b111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q   <= '0;
      fill_q  <= '0;
      timer_q <= '0;
      st_q    <= StEmpty;
      gen_q   <= '0;
      out_q   <= '0;
      valid_q <= '0;
      drop_q  <= 1'b0;
      speed_q <= '0;
      sts_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      timer_q <= timer_d;
      st_q    <= st_d;
      gen_q   <= GEN;
      out_q   <= out_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      speed_q <= speed_d;
      sts_q   <= state;
    end
  end

  always_comb begin
    pl_data      = '0;
    pl_tlpstart  = '0;
    pl_tlpend    = '0;
    pl_dllpstart = '0;
    pl_dllpend   = '0;
    pl_tlpedb    = '0;
    for (int i = 0; i < NBYTES; i++) begin
      pl_data[8*i +: 8] = out_q[i].data;
      pl_tlpstart[i]    = out_q[i].tlp_s;
      pl_tlpend[i]      = out_q[i].tlp_e;
      pl_dllpstart[i]   = out_q[i].dllp_s;
      pl_dllpend[i]     = out_q[i].dllp_e;
      pl_tlpedb[i]      = out_q[i].edb_m;
    end
  end

  assign pl_valid     = valid_q;
  assign pl_speedmode = speed_q;
  assign pl_state_sts = sts_q;
  assign pl_drop      = drop_q;

endmodule

// File: tb/tb_lpif_rx_packer.sv
module tb_lpif_rx_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  ts, te, ds, de, eb;
  logic [2:0]  gen;
  logic [3:0]  state;

  logic [3:0]  p_valid, p_ts, p_te, p_ds, p_de, p_eb, p_sts;
  logic [31:0] p_data;
  logic [2:0]  p_speed;
  logic        p_drop;

  logic [3:0]  n_valid, n_ts, n_te, n_ds, n_de, n_eb, n_sts;
  logic [31:0] n_data;
  logic [2:0]  n_speed;
  logic        n_drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lpif_rx_packer #(.NBYTES(4), .PACK(1), .TIMEOUT(3), .ACTIVE_STATE(4'h1)) u_pack (
    .clk(clk), .reset(reset), .packetValid(valid), .packetData(data),
    .tlpstart(ts), .tlpend(te), .dllpstart(ds), .dllpend(de), .edb(eb),
    .GEN(gen), .state(state),
    .pl_valid(p_valid), .pl_data(p_data), .pl_tlpstart(p_ts), .pl_tlpend(p_te),
    .pl_dllpstart(p_ds), .pl_dllpend(p_de), .pl_tlpedb(p_eb),
    .pl_speedmode(p_speed), .pl_state_sts(p_sts), .pl_drop(p_drop)
  );

  lpif_rx_packer #(.NBYTES(4), .PACK(0), .TIMEOUT(3), .ACTIVE_STATE(4'h1)) u_nopack (
    .clk(clk), .reset(reset), .packetValid(valid), .packetData(data),
    .tlpstart(ts), .tlpend(te), .dllpstart(ds), .dllpend(de), .edb(eb),
    .GEN(gen), .state(state),
    .pl_valid(n_valid), .pl_data(n_data), .pl_tlpstart(n_ts), .pl_tlpend(n_te),
    .pl_dllpstart(n_ds), .pl_dllpend(n_de), .pl_tlpedb(n_eb),
    .pl_speedmode(n_speed), .pl_state_sts(n_sts), .pl_drop(n_drop)
  );

  task automatic drive(input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] tlps, input logic [3:0] tlpe);
    valid = v; data = d; ts = tlps; te = tlpe; ds = 4'h0; de = 4'h0; eb = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    drive(4'h0, 32'h0, 4'h0, 4'h0);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; state = 4'h1; gen = 3'd3;
    drive(4'hF, 32'h12345678, 4'h0, 4'hF);
    step(); step();
    checks++; if (p_valid !== 4'h0) begin errors++;
      $display("FAIL reset_valid: got %b want %b", p_valid, 4'h0); end
    checks++; if (p_data !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h want %h", p_data, 32'h0); end
    checks++; if (p_te !== 4'h0) begin errors++;
      $display("FAIL reset_tlpend: got %b want %b", p_te, 4'h0); end
    checks++; if (p_speed !== 3'd0 || p_sts !== 4'h0 || p_drop !== 1'b0) begin errors++;
      $display("FAIL reset_side: got speed=%0d sts=%0d drop=%b want 0 0 0", p_speed, p_sts, p_drop);
    end
    reset = 1'b1;
    idle_step();
    checks++; if (p_speed !== 3'd2) begin errors++;
      $display("FAIL speed_gen3: got %0d want 2", p_speed); end
    checks++; if (p_sts !== 4'h1) begin errors++;
      $display("FAIL state_sts: got %0d want 1", p_sts); end
    checks++; if (p_valid !== 4'h0) begin errors++;
      $display("FAIL post_reset_valid: got %b want 0000", p_valid); end
  endtask

  task automatic test_full_beat();
    drive(4'hF, 32'h44332211, 4'h0, 4'h0);
    step();
    checks++; if (p_valid !== 4'hF || p_data !== 32'h44332211) begin errors++;
      $display("FAIL full_beat: got %b/%h want 1111/44332211", p_valid, p_data); end
    checks++; if (n_valid !== 4'hF || n_data !== 32'h44332211) begin errors++;
      $display("FAIL full_beat_nopack: got %b/%h want 1111/44332211", n_valid, n_data); end
    idle_step();
    checks++; if (p_valid !== 4'h0) begin errors++;
      $display("FAIL full_beat_nofill: got %b want 0000", p_valid); end
  endtask

  task automatic test_pack_sparse();
    drive(4'b1010, 32'hBB00AA00, 4'h0, 4'h0);
    step();
    checks++; if (p_valid !== 4'h0 || p_data !== 32'h0) begin errors++;
      $display("FAIL sparse_hold: got %b/%h want 0000/00000000", p_valid, p_data); end
    checks++; if (n_valid !== 4'b0011 || n_data !== 32'h0000BBAA) begin errors++;
      $display("FAIL sparse_nopack: got %b/%h want 0011/0000bbaa", n_valid, n_data); end
    drive(4'b0101, 32'h00DD00CC, 4'h0, 4'h0);
    step();
    checks++; if (p_valid !== 4'hF || p_data !== 32'hDDCCBBAA) begin errors++;
      $display("FAIL sparse_pack: got %b/%h want 1111/ddccbbaa", p_valid, p_data); end
    idle_step();
    checks++; if (p_valid !== 4'h0) begin errors++;
      $display("FAIL sparse_empty: got %b want 0000", p_valid); end
  endtask

  task automatic test_end_marker();
    drive(4'b0001, 32'h000000EE, 4'h0, 4'h0);
    eb = 4'b0001;
    step();
    checks++; if (p_valid !== 4'b0001 || p_eb !== 4'b0001) begin errors++;
      $display("FAIL edb_flush: got %b/%b want 0001/0001", p_valid, p_eb); end
    drive(4'b0111, 32'h00332211, 4'h0, 4'b0100);
    step();
    checks++; if (p_valid !== 4'b0111 || p_te !== 4'b0100 || p_data !== 32'h00332211) begin
      errors++;
      $display("FAIL tlpend_flush: got %b/%b/%h want 0111/0100/00332211", p_valid, p_te, p_data);
    end
    drive(4'b0111, 32'h00665544, 4'h0, 4'h0);
    step();
    checks++; if (p_valid !== 4'h0) begin errors++;
      $display("FAIL end_hold: got %b want 0000", p_valid); end
    drive(4'b0001, 32'h00000077, 4'h0, 4'b0001);
    step();
    checks++; if (p_valid !== 4'hF || p_data !== 32'h77665544 || p_te !== 4'b1000) begin
      errors++;
      $display("FAIL end_fill: got %b/%h/%b want 1111/77665544/1000", p_valid, p_data, p_te);
    end
    drive(4'b0111, 32'h00332211, 4'h0, 4'h0);
    step();
    drive(4'hF, 32'h77665544, 4'h0, 4'b1000);
    step();
    checks++; if (p_valid !== 4'hF || p_data !== 32'h44332211 || p_te !== 4'h0) begin errors++;
      $display("FAIL spill_first: got %b/%h/%b want 1111/44332211/0000", p_valid, p_data, p_te);
    end
    idle_step();
    checks++; if (p_valid !== 4'b0111 || p_data !== 32'h00776655 || p_te !== 4'b0100) begin
      errors++;
      $display("FAIL spill_resid: got %b/%h/%b want 0111/00776655/0100", p_valid, p_data, p_te);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] in3 [4];
    logic [31:0] exp3 [4];
    drive(4'hF, 32'hA4A3A2A1, 4'h0, 4'h0);
    step();
    checks++; if (p_data !== 32'hA4A3A2A1 || p_valid !== 4'hF) begin errors++;
      $display("FAIL b2b_0: got %b/%h want 1111/a4a3a2a1", p_valid, p_data); end
    drive(4'hF, 32'hB4B3B2B1, 4'h0, 4'h0);
    step();
    checks++; if (p_data !== 32'hB4B3B2B1 || p_valid !== 4'hF) begin errors++;
      $display("FAIL b2b_1: got %b/%h want 1111/b4b3b2b1", p_valid, p_data); end
    in3  = '{32'h00030201, 32'h00060504, 32'h00090807, 32'h000C0B0A};
    exp3 = '{32'h0, 32'h04030201, 32'h08070605, 32'h0C0B0A09};
    for (int k = 0; k < 4; k++) begin
      drive(4'b0111, in3[k], 4'h0, 4'h0);
      step();
      checks++; if (p_data !== exp3[k] || p_valid !== ((k == 0) ? 4'h0 : 4'hF)) begin errors++;
        $display("FAIL b2b_carry%0d: got %b/%h want data %h", k, p_valid, p_data, exp3[k]); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] pat [2];
    pat = '{32'h0000BBAA, 32'h0000DDCC};
    for (int r = 0; r < 2; r++) begin
      drive(4'b0011, pat[r], 4'h0, 4'h0);
      step();
      for (int k = 0; k < 4; k++) begin
        checks++; if (p_valid !== 4'h0) begin errors++;
          $display("FAIL timeout_hold r%0d c%0d: got %b want 0000", r, k, p_valid); end
        idle_step();
      end
      checks++; if (p_valid !== 4'b0011 || p_data !== pat[r]) begin errors++;
        $display("FAIL timeout_flush r%0d: got %b/%h want 0011/%h", r, p_valid, p_data, pat[r]);
      end
    end
    idle_step();
  endtask

  task automatic test_inactive_drop();
    drive(4'b0011, 32'h0000BBAA, 4'h0, 4'h0);
    step();
    state = 4'h0;
    drive(4'hF, 32'h55555555, 4'h0, 4'h0);
    step();
    checks++; if (p_drop !== 1'b1 || p_valid !== 4'h0 || p_sts !== 4'h0) begin errors++;
      $display("FAIL drop_pulse: got drop=%b valid=%b sts=%0d want 1 0000 0", p_drop, p_valid,
               p_sts);
    end
    checks++; if (n_drop !== 1'b0 || n_valid !== 4'h0) begin errors++;
      $display("FAIL drop_nopack: got drop=%b valid=%b want 0 0000", n_drop, n_valid); end
    state = 4'h1;
    drive(4'hF, 32'h44332211, 4'h0, 4'h0);
    step();
    checks++; if (p_drop !== 1'b0 || p_valid !== 4'hF || p_data !== 32'h44332211) begin
      errors++;
      $display("FAIL drop_clear: got drop=%b %b/%h want 0 1111/44332211", p_drop, p_valid, p_data);
    end
  endtask

  task automatic test_gen();
    logic [2:0] gens [5];
    logic [2:0] spd  [5];
    gens = '{3'd7, 3'd1, 3'd5, 3'd0, 3'd3};
    spd  = '{3'd7, 3'd0, 3'd4, 3'd7, 3'd2};
    for (int k = 0; k < 5; k++) begin
      gen = gens[k];
      idle_step();
      checks++; if (p_speed !== spd[k]) begin errors++;
        $display("FAIL speed_gen%0d: got %0d want %0d", gens[k], p_speed, spd[k]); end
    end
    drive(4'b0011, 32'h0000BBAA, 4'h0, 4'h0);
    step();
    gen = 3'd4;
    drive(4'hF, 32'h44332211, 4'h0, 4'h0);
    step();
    checks++; if (p_valid !== 4'b0011 || p_data !== 32'h0000BBAA) begin errors++;
      $display("FAIL gen_flush: got %b/%h want 0011/0000bbaa", p_valid, p_data); end
    idle_step();
    checks++; if (p_valid !== 4'hF || p_data !== 32'h44332211) begin errors++;
      $display("FAIL gen_follow: got %b/%h want 1111/44332211", p_valid, p_data); end
    gen = 3'd3;
    idle_step();
  endtask

  task automatic test_reset_mid();
    drive(4'b0011, 32'h0000BBAA, 4'h0, 4'h0);
    step();
    reset = 1'b0;
    idle_step();
    checks++; if (p_drop !== 1'b0 || p_valid !== 4'h0) begin errors++;
      $display("FAIL reset_mid: got drop=%b valid=%b want 0 0000", p_drop, p_valid); end
    reset = 1'b1;
    drive(4'hF, 32'hC4C3C2C1, 4'h0, 4'h0);
    step();
    checks++; if (p_valid !== 4'hF || p_data !== 32'hC4C3C2C1) begin errors++;
      $display("FAIL reset_mid_clean: got %b/%h want 1111/c4c3c2c1", p_valid, p_data); end
  endtask

  task automatic test_nopack();
    drive(4'b0110, 32'h00BBAA00, 4'b0010, 4'b0100);
    step();
    checks++; if (n_valid !== 4'b0011 || n_data !== 32'h0000BBAA) begin errors++;
      $display("FAIL nopack_compact: got %b/%h want 0011/0000bbaa", n_valid, n_data); end
    checks++; if (n_te !== 4'b0010 || n_ts !== 4'b0001) begin errors++;
      $display("FAIL nopack_markers: got te=%b ts=%b want 0010 0001", n_te, n_ts); end
    checks++; if (p_valid !== 4'b0011 || p_te !== 4'b0010) begin errors++;
      $display("FAIL pack_marker_flush: got %b/%b want 0011/0010", p_valid, p_te); end
    drive(4'b0010, 32'h0000CC00, 4'h0, 4'h0);
    step();
    checks++; if (n_valid !== 4'b0001 || n_data !== 32'h000000CC) begin errors++;
      $display("FAIL nopack_single: got %b/%h want 0001/000000cc", n_valid, n_data); end
    checks++; if (p_valid !== 4'h0) begin errors++;
      $display("FAIL pack_single_hold: got %b want 0000", p_valid); end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_pack_sparse();
    test_end_marker();
    test_back_to_back();
    test_timeout();
    test_inactive_drop();
    test_gen();
    test_reset_mid();
    test_nopack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
